// File: rtl/crc_pkg.sv
// Shared definitions for the streaming CRC engine.
// Default configuration is ISO14443-A CRC_A.
package crc_pkg;

  localparam logic [15:0] CRC_A_POLY    = 16'h1021;
  localparam logic [15:0] CRC_A_INIT    = 16'h6363;
  localparam bit          CRC_A_REFIN   = 1'b1;
  localparam bit          CRC_A_REFOUT  = 1'b1;
  localparam logic [15:0] CRC_A_XOROUT  = 16'h0000;
  localparam logic [15:0] CRC_A_RESIDUE = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } crc_state_e;

  // Reverse the low w bits of v; upper bits come back zero.
  function automatic logic [31:0] rev_bits(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    r = {<<{v}};
    return r >> (32 - w);
  endfunction

endpackage

// File: rtl/crc_stream_engine_step.sv
// Combinational CRC update over one input beat.
// Bytes are taken [7:0] first; bit order within a byte follows REFIN.
module crc_step
  import crc_pkg::*;
#(
  parameter int               DATA_W = 8,
  parameter int               CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC_A_POLY),
  parameter bit               REFIN  = CRC_A_REFIN
) (
  input  logic [CRC_W-1:0]  i_crc,
  input  logic [DATA_W-1:0] i_data,
  output logic [CRC_W-1:0]  o_crc
);

  localparam logic [CRC_W-1:0] RPOLY =
    CRC_W'(rev_bits(32'(POLY), CRC_W));

  logic [CRC_W-1:0] w_acc;
  logic             w_fb;

  always_comb begin
    w_acc = i_crc;
    w_fb  = 1'b0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      for (int i = 0; i < 8; i++) begin
        if (REFIN) begin
          w_fb  = w_acc[0] ^ i_data[8*b+i];
          w_acc = (w_acc >> 1) ^ (w_fb ? RPOLY : '0);
        end else begin
          w_fb  = w_acc[CRC_W-1] ^ i_data[8*b+7-i];
          w_acc = (w_acc << 1) ^ (w_fb ? POLY : '0);
        end
      end
    end
    o_crc = w_acc;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Framed streaming CRC generator/checker with
// per-frame result, beat count and residue flag.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int               DATA_W  = 8,
  parameter int               CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC_A_POLY),
  parameter logic [CRC_W-1:0] INIT    = CRC_W'(CRC_A_INIT),
  parameter bit               REFIN   = CRC_A_REFIN,
  parameter bit               REFOUT  = CRC_A_REFOUT,
  parameter logic [CRC_W-1:0] XOROUT  = CRC_W'(CRC_A_XOROUT),
  parameter logic [CRC_W-1:0] RESIDUE = CRC_W'(CRC_A_RESIDUE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_first,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CRC_W-1:0]  m_crc,
  output logic [15:0]       m_len,
  output logic              check_ok
);

  crc_state_e       r_state;
  crc_state_e       w_state_nxt;
  logic             r_rdy_en;
  logic [CRC_W-1:0] r_crc;
  logic [15:0]      r_cnt;
  logic             r_m_valid;
  logic [CRC_W-1:0] r_m_crc;
  logic [15:0]      r_m_len;
  logic             r_check;

  logic             w_accept;
  logic             w_restart;
  logic             w_pop;
  logic [CRC_W-1:0] w_base;
  logic [CRC_W-1:0] w_crc_nxt;
  logic [CRC_W-1:0] w_res;
  logic [15:0]      w_cnt_nxt;

  assign s_ready   = r_rdy_en & (r_state != HOLD);
  assign w_accept  = s_valid & s_ready;
  assign w_pop     = (r_state == HOLD) & r_m_valid & m_ready;
  assign w_restart = (r_state == IDLE) | s_first;
  assign w_base    = w_restart ? INIT : r_crc;

  assign w_cnt_nxt = w_restart ? 16'd1 :
                     (&r_cnt) ? r_cnt : r_cnt + 16'd1;

  crc_step #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .REFIN  (REFIN)
  ) u_step (
    .i_crc  (w_base),
    .i_data (s_data),
    .o_crc  (w_crc_nxt)
  );

  // Register is already reflected when REFIN=1.
  assign w_res = ((REFOUT != REFIN) ?
    CRC_W'(rev_bits(32'(w_crc_nxt), CRC_W)) :
    w_crc_nxt) ^ XOROUT;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, RUN: begin
        if (w_accept)
          w_state_nxt = s_last ? HOLD : RUN;
      end
      HOLD: begin
        if (w_pop)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc     <= INIT;
      r_cnt     <= '0;
      r_m_valid <= 1'b0;
      r_m_crc   <= '0;
      r_m_len   <= '0;
      r_check   <= 1'b0;
    end else if (w_accept) begin
      r_crc <= w_crc_nxt;
      r_cnt <= w_cnt_nxt;
      if (s_last) begin
        r_m_valid <= 1'b1;
        r_m_crc   <= w_res;
        r_m_len   <= w_cnt_nxt;
        r_check   <= (w_res == RESIDUE);
      end
    end else if (w_pop) begin
      r_m_valid <= 1'b0;
      r_crc     <= INIT;
      r_cnt     <= '0;
    end
  end

  assign m_valid  = r_m_valid;
  assign m_crc    = r_m_crc;
  assign m_len    = r_m_len;
  assign check_ok = r_check & r_m_valid;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine:
// CRC_A vectors on 8-bit and 16-bit beat instances.
module tb_crc_stream_engine;

  typedef logic [15:0] wq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        v8, v16, mr8, mr16;
  logic        rdy8, rdy16, mv8, mv16;
  logic        ok8, ok16;
  logic [15:0] data;
  logic        first, last;
  logic [15:0] crc8, crc16, len8, len16;
  logic        sel16;

  logic        mv, rdy, ok;
  logic [15:0] mcrc, mlen;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mv   = sel16 ? mv16  : mv8;
  assign rdy  = sel16 ? rdy16 : rdy8;
  assign ok   = sel16 ? ok16  : ok8;
  assign mcrc = sel16 ? crc16 : crc8;
  assign mlen = sel16 ? len16 : len8;

  crc_stream_engine u8 (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (v8),
    .s_ready  (rdy8),
    .s_data   (data[7:0]),
    .s_first  (first),
    .s_last   (last),
    .m_valid  (mv8),
    .m_ready  (mr8),
    .m_crc    (crc8),
    .m_len    (len8),
    .check_ok (ok8)
  );

  crc_stream_engine #(.DATA_W(16)) u16 (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (v16),
    .s_ready  (rdy16),
    .s_data   (data),
    .s_first  (first),
    .s_last   (last),
    .m_valid  (mv16),
    .m_ready  (mr16),
    .m_crc    (crc16),
    .m_len    (len16),
    .check_ok (ok16)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic beat(
    input logic [15:0] d,
    input logic        f,
    input logic        l,
    input int          gap
  );
    int n;
    repeat (gap) @(negedge clk);
    data  = d;
    first = f;
    last  = l;
    if (sel16) v16 = 1'b1;
    else       v8  = 1'b1;
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    @(posedge clk);
    #1;
    v8  = 1'b0;
    v16 = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame(input wq_t q, input bit rnd);
    int g;
    for (int i = 0; i < q.size(); i++) begin
      g = 0;
      if (rnd && $urandom_range(0, 1) == 1)
        g = int'($urandom_range(1, 3));
      beat(q[i], i == 0, i == q.size() - 1, g);
    end
  endtask

  task automatic wait_res(input string tag);
    int n;
    n = 0;
    while (!mv && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(mv), 32'd1);
  endtask

  task automatic pop();
    if (sel16) mr16 = 1'b1;
    else       mr8  = 1'b1;
    @(negedge clk);
    mr8  = 1'b0;
    mr16 = 1'b0;
  endtask

  initial begin
    wq_t q1, qa, qb, qc, qd, q10, qw1, qw2;
    q1  = '{16'h31, 16'h32, 16'h33, 16'h34,
            16'h35, 16'h36, 16'h37, 16'h38,
            16'h39};
    q10 = '{16'h31, 16'h32, 16'h33, 16'h34,
            16'h35, 16'h36, 16'h37, 16'h38,
            16'h39, 16'h00};
    qa  = '{16'h00, 16'h00};
    qb  = '{16'h00, 16'h00, 16'hA0, 16'h1E};
    qc  = '{16'h00, 16'h00, 16'hA0, 16'h1F};
    qd  = '{16'h00, 16'h00, 16'hA0, 16'h1E};
    qw1 = '{16'h3231, 16'h3433, 16'h3635,
            16'h3837, 16'h0039};
    qw2 = '{16'h0000, 16'h1EA0};

    reset = 1'b1;
    v8 = 0; v16 = 0; mr8 = 0; mr16 = 0;
    data = '0; first = 0; last = 0;
    sel16 = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(mv), 32'd0);
    chk("rst_crc", 32'(mcrc), 32'd0);
    chk("rst_len", 32'(mlen), 32'd0);
    chk("rst_ok", 32'(ok), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(rdy), 32'd1);

    for (int i = 0; i < 8; i++)
      beat(q1[i], i == 0, 1'b0, 0);
    chk("t1_pre_valid", 32'(mv), 32'd0);
    beat(q1[8], 1'b0, 1'b1, 0);
    chk("t1_valid_lat", 32'(mv), 32'd1);
    chk("t1_crc", 32'(mcrc), 32'hBF05);
    chk("t1_len", 32'(mlen), 32'd9);
    chk("t1_ok", 32'(ok), 32'd0);

    data = 16'h00; first = 1'b1; last = 1'b0;
    v8 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_ready_low", 32'(rdy), 32'd0);
      chk("t3_crc_hold", 32'(mcrc), 32'hBF05);
      chk("t3_valid_hold", 32'(mv), 32'd1);
    end
    pop();
    chk("t3_popped", 32'(mv), 32'd0);
    beat(16'h00, 1'b1, 1'b0, 0);
    beat(16'h00, 1'b0, 1'b1, 0);
    wait_res("t3_valid");
    chk("t3_crc", 32'(mcrc), 32'h1EA0);
    chk("t3_len", 32'(mlen), 32'd2);
    pop();

    frame(qa, 1'b0);
    wait_res("t2a_valid");
    chk("t2a_crc", 32'(mcrc), 32'h1EA0);
    pop();
    frame(qb, 1'b0);
    wait_res("t2b_valid");
    chk("t2b_crc", 32'(mcrc), 32'h0000);
    chk("t2b_ok", 32'(ok), 32'd1);
    chk("t2b_len", 32'(mlen), 32'd4);
    pop();
    chk("t2b_ok_qual", 32'(ok), 32'd0);
    frame(qc, 1'b0);
    wait_res("t2c_valid");
    chk("t2c_ok", 32'(ok), 32'd0);
    pop();

    beat(16'hAA, 1'b1, 1'b0, 0);
    beat(16'h55, 1'b0, 1'b0, 0);
    beat(16'h00, 1'b1, 1'b0, 0);
    beat(16'h00, 1'b0, 1'b1, 0);
    wait_res("t4_valid");
    chk("t4_crc", 32'(mcrc), 32'h1EA0);
    chk("t4_len", 32'(mlen), 32'd2);
    pop();

    for (int i = 0; i < 4; i++)
      beat(q1[i], i == 0, 1'b0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_valid", 32'(mv), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_valid", 32'(mv), 32'd0);
    chk("t5_ready", 32'(rdy), 32'd1);
    frame(q1, 1'b0);
    wait_res("t5_valid");
    chk("t5_crc", 32'(mcrc), 32'hBF05);
    chk("t5_len", 32'(mlen), 32'd9);
    pop();

    frame(q1, 1'b1);
    wait_res("t6_valid");
    chk("t6_crc", 32'(mcrc), 32'hBF05);
    chk("t6_len", 32'(mlen), 32'd9);
    pop();
    frame(q10, 1'b1);
    wait_res("t6z_valid");
    chk("t6z_crc", 32'(mcrc), 32'h5712);
    chk("t6z_len", 32'(mlen), 32'd10);
    pop();

    sel16 = 1'b1;
    frame(qw1, 1'b1);
    wait_res("w16_valid");
    chk("w16_crc", 32'(mcrc), 32'h5712);
    chk("w16_len", 32'(mlen), 32'd5);
    pop();
    frame(qw2, 1'b0);
    wait_res("w16r_valid");
    chk("w16r_crc", 32'(mcrc), 32'h0000);
    chk("w16r_ok", 32'(ok), 32'd1);
    pop();

    sel16 = 1'b0;
    frame(qd, 1'b0);
    wait_res("t2d_valid");
    chk("t2d_ok", 32'(ok), 32'd1);
    pop();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
